// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the data-memory bridge.
//   lsu_state_e   - bridge FSM states
//   DM_*          - DMCtrl size/sign codes (same encoding as load/store funct3)
//   BE_W          - byte-enable width of the word bus
//   dm_ctrl_legal - 1 when a DMCtrl code names a real access size
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } lsu_state_e;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  localparam int BE_W = 4;

  function automatic logic dm_ctrl_legal(input logic [2:0] ctrl);
    return (ctrl == DM_B) || (ctrl == DM_H) || (ctrl == DM_W) ||
           (ctrl == DM_BU) || (ctrl == DM_HU);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational byte-lane steering.
//   dm_ctrl_i     - DMCtrl size/sign code
//   addr_lo_i     - Address[1:0]
//   store_data_i  - raw store data (rs2)
//   load_word_i   - raw bus read word
//   store_wdata_o - lane-replicated store data
//   store_be_o    - byte enables for the store
//   load_data_o   - shifted and sign/zero-extended load data
// Misaligned halfword/word addresses are folded: halfword uses Address[1]
// only, word always uses lane 0.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]      dm_ctrl_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [31:0]     store_data_i,
  input  logic [31:0]     load_word_i,
  output logic [31:0]     store_wdata_o,
  output logic [BE_W-1:0] store_be_o,
  output logic [31:0]     load_data_o
);

  logic [1:0]  lane;
  logic [31:0] shifted;

  always_comb begin
    store_wdata_o = store_data_i;
    store_be_o    = '1;
    lane          = 2'd0;
    case (dm_ctrl_i)
      DM_B, DM_BU: begin
        store_wdata_o = {4{store_data_i[7:0]}};
        store_be_o    = BE_W'(1) << addr_lo_i;
        lane          = addr_lo_i;
      end
      DM_H, DM_HU: begin
        store_wdata_o = {2{store_data_i[15:0]}};
        store_be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        lane          = {addr_lo_i[1], 1'b0};
      end
      default: ;
    endcase

    shifted = load_word_i >> {lane, 3'b000};

    case (dm_ctrl_i)
      DM_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      DM_BU:   load_data_o = {24'd0, shifted[7:0]};
      DM_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      DM_HU:   load_data_o = {16'd0, shifted[15:0]};
      default: load_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_dm_bridge.sv
// lsu_dm_bridge: turns the core's single-cycle data-memory interface into
// accesses on a word-wide valid/grant bus, stalling the core meanwhile.
//   clk, rst_n           - clock, asynchronous active-low reset
//   mem_op/DMWr/DMCtrl   - access request, direction, size/sign code
//   Address/DataWr       - byte address and store data from the core
//   DataRd               - formatted load data, valid in DONE
//   stall                - freeze PC/register file
//   bus_err              - one-cycle pulse on timeout (or misalign trap)
//   mem_req/we/addr/wdata/be, mem_gnt/rvalid/rdata - memory bus
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword
// and word accesses instead of folding them onto aligned lanes.
module lsu_dm_bridge
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_op,
  input  logic              DMWr,
  input  logic [2:0]        DMCtrl,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataWr,
  output logic [31:0]       DataRd,
  output logic              stall,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The timeout fires in the WAIT_R cycle whose count is LAST, giving
  // exactly TIMEOUT_CYCLES cycles in WAIT_R.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       st_wdata;
  logic [BE_W-1:0]   st_be;
  logic [31:0]       ld_data;
  logic              misalign;

  lsu_lane_align u_align (
    .dm_ctrl_i    (DMCtrl),
    .addr_lo_i    (Address[1:0]),
    .store_data_i (DataWr),
    .load_word_i  (mem_rdata),
    .store_wdata_o(st_wdata),
    .store_be_o   (st_be),
    .load_data_o  (ld_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((DMCtrl[1:0] == 2'b01) && Address[0]) ||
                    ((DMCtrl == DM_W) && (Address[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (!dm_ctrl_legal(DMCtrl) || misalign) begin
            // No bus access: finish at once with zeroed load data.
            state_d = DONE;
            rdata_d = '0;
            err_d   = misalign;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = DMWr;
        mem_addr  = {Address[ADDR_W-1:2], 2'b00};
        mem_wdata = st_wdata;
        mem_be    = st_be;
        if (mem_gnt) begin
          if (DMWr) begin
            state_d = DONE;
          end else if (mem_rvalid) begin
            rdata_d = ld_data;
            state_d = DONE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // Data arriving in the last allowed cycle still wins over timeout.
        if (mem_rvalid) begin
          rdata_d = ld_data;
          state_d = DONE;
        end else if (cnt_q >= CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign DataRd  = rdata_q;
  assign bus_err = err_q;
  // The core advances on the edge that ends the DONE cycle.
  assign stall   = mem_op & (state_q != DONE);

endmodule

// File: tb/tb_lsu_dm_bridge.sv
module tb_lsu_dm_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_op, DMWr;
  logic [2:0]  DMCtrl;
  logic [31:0] Address, DataWr, DataRd;
  logic        stall, bus_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_bad = 0;

  lsu_dm_bridge #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_op(mem_op), .DMWr(DMWr), .DMCtrl(DMCtrl),
    .Address(Address), .DataWr(DataWr), .DataRd(DataRd), .stall(stall),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: which byte the access starts at, given size folding.
  function automatic int start_byte(input logic [2:0] ctl, input logic [31:0] adr);
    if (ctl == 3'd0 || ctl == 3'd4) return int'(adr[1:0]);
    if (ctl == 3'd1 || ctl == 3'd5) return int'(adr[1]) * 2;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] ctl, input logic [31:0] adr,
                                             input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * start_byte(ctl, adr));
    case (ctl)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v - 32'd256;   end
      3'd4: v = v % 256;
      3'd1: begin v = v % 65536; if (v >= 32768) v = v - 32'd65536; end
      3'd5: v = v % 65536;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] ctl, input logic [31:0] d);
    if (ctl == 3'd0 || ctl == 3'd4) return (d % 256) * 32'h01010101;
    if (ctl == 3'd1 || ctl == 3'd5) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] ctl, input logic [31:0] adr);
    if (ctl == 3'd0 || ctl == 3'd4) return 32'd1 << start_byte(ctl, adr);
    if (ctl == 3'd1 || ctl == 3'd5) return 32'd3 << start_byte(ctl, adr);
    return 32'hF;
  endfunction

  // One core access. g = cycles spent in REQ before gnt; rv = cycles from
  // gnt to rvalid (0 = same cycle, -1 = never). Called at a negedge with
  // the bridge idle.
  task automatic run_txn(input logic we, input logic [2:0] ctl, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int g, input int rv);
    logic legal, trap, normal, exp_err, chk_rd, in_req;
    logic [31:0] exp_rd;
    int done;
    legal = (ctl == 3'd0) || (ctl == 3'd1) || (ctl == 3'd2) || (ctl == 3'd4) || (ctl == 3'd5);
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = legal && ((((ctl == 3'd1) || (ctl == 3'd5)) && adr[0]) ||
                     ((ctl == 3'd2) && (adr[1:0] != 2'b00)));
`endif
    normal  = legal && !trap;
    exp_err = 1'b0;
    exp_rd  = 32'd0;
    chk_rd  = 1'b1;
    if (!normal) begin
      done = 1; exp_err = trap;
    end else if (we) begin
      done = 2 + g; chk_rd = 1'b0;
    end else if (rv >= 0 && rv <= TMO) begin
      done = 2 + g + rv; exp_rd = model_load(ctl, adr, rd);
    end else begin
      done = 2 + g + TMO; exp_err = 1'b1;
    end
    for (int c = 0; c <= done; c++) begin
      mem_op     = 1'b1;
      DMWr       = we;
      DMCtrl     = ctl;
      Address    = adr;
      DataWr     = wd;
      in_req     = normal && (c >= 1) && (c <= 1 + g);
      mem_gnt    = normal && (c == 1 + g);
      mem_rvalid = normal && !we && (rv >= 0) && (c == 1 + g + rv);
      mem_rdata  = mem_rvalid ? rd : $urandom;
      #1;
      check("stall", stall, c < done);
      check("req", mem_req, in_req);
      check("err", bus_err, (c == done) ? exp_err : 1'b0);
      if (in_req) begin
        check("we", mem_we, we);
        check("addr", mem_addr, {adr[31:2], 2'b00});
        check("be", mem_be, model_be(ctl, adr));
        if (we) check("wdata", mem_wdata, model_wdata(ctl, wd));
      end else begin
        check("addr0", mem_addr, 32'd0);
        check("be0", mem_be, 32'd0);
      end
      if (c == done && chk_rd) check("rdata", DataRd, exp_rd);
      @(negedge clk);
    end
    mem_op = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    int rsel;
    rst_n = 1'b0; mem_op = 1'b0; DMWr = 1'b0; DMCtrl = 3'd0; Address = '0;
    DataWr = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", mem_req, 1'b0);
    check("rst_err", bus_err, 1'b0);
    check("rst_rd", DataRd, 32'd0);
    check("rst_stall", stall, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed accesses
    run_txn(1'b1, 3'd0, 32'h1003, 32'h000000A5, 32'd0, 0, 0);       // SB
    run_txn(1'b0, 3'd0, 32'h2002, 32'd0, 32'h0080FF00, 1, 3);       // LB
    run_txn(1'b0, 3'd4, 32'h2002, 32'd0, 32'h0080FF00, 0, 3);       // LBU
    run_txn(1'b0, 3'd1, 32'h0000, 32'd0, 32'h12348001, 0, 0);       // LH, gnt+rvalid
    run_txn(1'b0, 3'd2, 32'h0010, 32'd0, 32'hDEADBEEF, 0, -1);      // LW timeout
    run_txn(1'b0, 3'd2, 32'h3002, 32'd0, 32'hCAFEF00D, 2, 1);       // LW misaligned
    run_txn(1'b1, 3'd1, 32'h4002, 32'h1234ABCD, 32'd0, 1, 0);       // SH upper
    run_txn(1'b0, 3'd3, 32'h5000, 32'd0, 32'd0, 0, 0);              // illegal
    run_txn(1'b0, 3'd5, 32'h6002, 32'd0, 32'h9ABC1234, 0, 4);       // LHU, last cycle

    // Reset while in REQ: request drops immediately
    mem_op = 1'b1; DMWr = 1'b0; DMCtrl = 3'd2; Address = 32'h40;
    @(negedge clk);
    #1 check("pre_rst_req", mem_req, 1'b1);
    rst_n = 1'b0;
    #1 check("rst_in_req", mem_req, 1'b0);
    check("rst_in_req_addr", mem_addr, 32'd0);
    mem_op = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 3'd2, 32'h80, 32'd0, 32'h55AA55AA, 0, 1);         // sets DataRd

    // Reset while in WAIT_R
    mem_op = 1'b1; DMWr = 1'b0; DMCtrl = 3'd2; Address = 32'h44;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1 check("wait_req", mem_req, 1'b0);
    check("wait_stall", stall, 1'b1);
    rst_n = 1'b0;
    #1 check("rst_wait_rd", DataRd, 32'd0);
    check("rst_wait_err", bus_err, 1'b0);
    check("rst_wait_stall", stall, 1'b1);
    mem_op = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b1, 3'd2, 32'h7000, 32'h0BADF00D, 32'd0, 1, 0);       // SW after reset

    // Randomized accesses
    for (int i = 0; i < 250; i++) begin
      rsel = int'($urandom_range(0, 5));
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom, int'($urandom_range(0, 3)), (rsel == 5) ? -1 : rsel);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
